// File: rtl/free_list.sv
// free_list: circular free list of physical register tags for a 2-wide rename stage.
// Revision 1.0 - initial release.
`default_nettype none

module free_list #(
  parameter int PREG_NUMBER    = 64,
  parameter int ARCHREG_NUMBER = 32,
  localparam int DEPTH = PREG_NUMBER - ARCHREG_NUMBER,
  localparam int PW    = $clog2(PREG_NUMBER),
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          alloc_req_i,
  input  logic [1:0]          retire_en_i,
  input  logic [1:0][PW-1:0]  T_old_i,
  input  logic                branch_recover_i,
  output logic [1:0][PW-1:0]  free_preg_o,
  output logic [1:0]          alloc_gnt_o,
  output logic [CW-1:0]       free_count_o,
  output logic [1:0]          fl_status_o
);

  localparam logic [1:0] FL_FULL      = 2'd0;
  localparam logic [1:0] FL_ONE_LEFT  = 2'd1;
  localparam logic [1:0] FL_MORE_LEFT = 2'd2;

  logic [PW-1:0] list_q [DEPTH];
  logic [PW-1:0] list_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW-1:0] chead_q, chead_d;
  logic [CW-1:0] count_q, count_d;

  logic [1:0]    honoured;
  logic [1:0]    n_req;
  logic [1:0]    n_gnt;
  logic [1:0]    n_ret;
  logic [AW-1:0] wr1_ptr;

  // Pointers advance by at most 2 per cycle, so one conditional subtract wraps them.
  function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p, input logic [1:0] n);
    logic [AW:0] s;
    s = {1'b0, p} + (AW+1)'(n);
    if (s >= (AW+1)'(DEPTH)) s = s - (AW+1)'(DEPTH);
    return s[AW-1:0];
  endfunction

  always_comb begin
    honoured    = {alloc_req_i[1] & alloc_req_i[0], alloc_req_i[0]};
    n_req       = {1'b0, honoured[0]} + {1'b0, honoured[1]};
    alloc_gnt_o = 2'b00;
    if (!branch_recover_i && (CW'(n_req) <= count_q)) alloc_gnt_o = honoured;
    n_gnt = {1'b0, alloc_gnt_o[0]} + {1'b0, alloc_gnt_o[1]};
    n_ret = {1'b0, retire_en_i[0]} + {1'b0, retire_en_i[1]};

    // Slot1 lands behind slot0 only when slot0 also returned a tag.
    wr1_ptr = ptr_add(tail_q, {1'b0, retire_en_i[0]});
    list_d  = list_q;
    if (retire_en_i[0]) list_d[tail_q]  = T_old_i[0];
    if (retire_en_i[1]) list_d[wr1_ptr] = T_old_i[1];

    tail_d  = ptr_add(tail_q, n_ret);
    chead_d = ptr_add(chead_q, n_ret);
    if (branch_recover_i) begin
      head_d  = chead_d;
      count_d = CW'(DEPTH);
    end else begin
      head_d  = ptr_add(head_q, n_gnt);
      count_d = count_q - CW'(n_gnt) + CW'(n_ret);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) list_q[i] <= PW'(ARCHREG_NUMBER + i);
      head_q  <= '0;
      tail_q  <= '0;
      chead_q <= '0;
      count_q <= CW'(DEPTH);
    end else begin
      list_q  <= list_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      chead_q <= chead_d;
      count_q <= count_d;
    end
  end

  assign free_preg_o[0] = list_q[head_q];
  assign free_preg_o[1] = list_q[ptr_add(head_q, 2'd1)];
  assign free_count_o   = count_q;
  assign fl_status_o    = (count_q >= CW'(2)) ? FL_MORE_LEFT :
                          (count_q == CW'(1)) ? FL_ONE_LEFT  : FL_FULL;

`ifndef SYNTHESIS
  // Returned tags can never outnumber the tags currently handed out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (int'(count_q) - int'(n_gnt) + int'(n_ret) <= DEPTH)
        else $error("free_list: push overflows list");
      assert (int'(n_ret) <= DEPTH - int'(count_q))
        else $error("free_list: committed head passes allocation head");
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_free_list.sv
// tb_free_list: directed stimulus with an abstract free-list model checked every cycle.
// Revision 1.0 - initial release.
`default_nettype none

module tb_free_list;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      alloc_req;
  logic [1:0]      retire_en;
  logic [1:0][5:0] t_old;
  logic            recover;
  logic [1:0][5:0] free_preg;
  logic [1:0]      alloc_gnt;
  logic [5:0]      free_count;
  logic [1:0]      fl_status;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  free_list dut (
    .clk              (clk),
    .reset            (reset),
    .alloc_req_i      (alloc_req),
    .retire_en_i      (retire_en),
    .T_old_i          (t_old),
    .branch_recover_i (recover),
    .free_preg_o      (free_preg),
    .alloc_gnt_o      (alloc_gnt),
    .free_count_o     (free_count),
    .fl_status_o      (fl_status)
  );

  // Model: unbounded allocation/free/commit counters over a 32-slot tag ring.
  int       m_alloc, m_free, m_commit, m_count;
  bit       m_valid = 1'b0;
  bit [5:0] m_ring [32];

  function automatic bit [1:0] exp_gnt();
    int want;
    want = alloc_req[0] ? (alloc_req[1] ? 2 : 1) : 0;
    if (recover || want == 0 || want > m_count) return 2'b00;
    return (want == 2) ? 2'b11 : 2'b01;
  endfunction

  function automatic int exp_status(int c);
    return (c >= 2) ? 2 : (c == 1) ? 1 : 0;
  endfunction

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit [1:0] g;
    int nret;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_ring[i] = 6'(32 + i);
      m_alloc = 0; m_free = 0; m_commit = 0; m_count = 32;
      m_valid = 1'b1;
    end else if (m_valid) begin
      g    = exp_gnt();
      nret = int'(retire_en[0]) + int'(retire_en[1]);
      for (int s = 0; s < 2; s++)
        if (retire_en[s]) begin
          m_ring[m_free % 32] = t_old[s];
          m_free++;
        end
      m_commit += nret;
      if (recover) begin
        m_alloc = m_commit;
        m_count = 32;
      end else begin
        m_alloc += int'(g[0]) + int'(g[1]);
        m_count  = m_count - (int'(g[0]) + int'(g[1])) + nret;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_free0", int'(free_preg[0]), int'(m_ring[m_alloc % 32]));
      check("model_free1", int'(free_preg[1]), int'(m_ring[(m_alloc + 1) % 32]));
      check("model_gnt", int'(alloc_gnt), int'(exp_gnt()));
      check("model_count", int'(free_count), m_count);
      check("model_status", int'(fl_status), exp_status(m_count));
    end
  end

  task automatic cyc(input bit rst, input bit [1:0] req, input bit [1:0] ret,
                     input int t0, input int t1, input bit rec);
    @(posedge clk);
    #1;
    reset     = rst;
    alloc_req = req;
    retire_en = ret;
    t_old[0]  = 6'(t0);
    t_old[1]  = 6'(t1);
    recover   = rec;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; alloc_req = 2'b00; retire_en = 2'b00; t_old = '0; recover = 1'b0;
    cyc(1, 2'b00, 2'b00, 0, 0, 0);
    cyc(0, 2'b00, 2'b00, 0, 0, 0);
    check("rst_free0", int'(free_preg[0]), 32);
    check("rst_free1", int'(free_preg[1]), 33);
    check("rst_count", int'(free_count), 32);
    check("rst_status", int'(fl_status), 2);
    check("rst_gnt", int'(alloc_gnt), 0);

    // Drain the whole list two tags per cycle.
    for (int k = 0; k < 16; k++) begin
      cyc(0, 2'b11, 2'b00, 0, 0, 0);
      check("drain_gnt", int'(alloc_gnt), 3);
      check("drain_free0", int'(free_preg[0]), 32 + 2 * k);
      check("drain_free1", int'(free_preg[1]), 33 + 2 * k);
    end
    cyc(0, 2'b01, 2'b00, 0, 0, 0);
    check("empty_count", int'(free_count), 0);
    check("empty_status", int'(fl_status), 0);
    check("empty_gnt", int'(alloc_gnt), 0);

    // Retire into an empty list; tags not visible until next cycle.
    cyc(0, 2'b01, 2'b11, 7, 5, 0);
    check("ret_same_gnt", int'(alloc_gnt), 0);
    cyc(0, 2'b00, 2'b00, 0, 0, 0);
    check("ret_count", int'(free_count), 2);
    check("ret_free0", int'(free_preg[0]), 7);
    check("ret_free1", int'(free_preg[1]), 5);

    cyc(0, 2'b01, 2'b00, 0, 0, 0);
    check("one_gnt01", int'(alloc_gnt), 1);
    cyc(0, 2'b11, 2'b00, 0, 0, 0);
    check("one_count", int'(free_count), 1);
    check("one_gnt11", int'(alloc_gnt), 0);
    cyc(0, 2'b01, 2'b00, 0, 0, 0);
    check("one_count_held", int'(free_count), 1);
    check("one_gnt01b", int'(alloc_gnt), 1);
    check("one_free0", int'(free_preg[0]), 5);
    cyc(0, 2'b00, 2'b00, 0, 0, 0);
    check("one_count_zero", int'(free_count), 0);

    // Steady alloc/retire streaming 40 tags through the ring and across the wrap.
    cyc(0, 2'b00, 2'b11, 3, 4, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 2'b11, 2'b11, 5 + 2 * i, 6 + 2 * i, 0);
      if (i == 0) begin
        check("wrap_first0", int'(free_preg[0]), 3);
        check("wrap_first1", int'(free_preg[1]), 4);
      end
      if (i == 19) check("wrap_last0", int'(free_preg[0]), 41);
    end

    // Reset wins over simultaneous allocate, retire and recover.
    cyc(1, 2'b11, 2'b11, 9, 9, 1);
    cyc(0, 2'b00, 2'b00, 0, 0, 0);
    check("rst2_free0", int'(free_preg[0]), 32);
    check("rst2_free1", int'(free_preg[1]), 33);
    check("rst2_count", int'(free_count), 32);

    // Six allocations, two retires, then recover with one retire.
    for (int k = 0; k < 3; k++) cyc(0, 2'b11, 2'b00, 0, 0, 0);
    cyc(0, 2'b00, 2'b11, 1, 2, 0);
    check("rec_pre_count", int'(free_count), 26);
    cyc(0, 2'b11, 2'b01, 3, 0, 1);
    check("rec_gnt", int'(alloc_gnt), 0);
    check("rec_before_count", int'(free_count), 28);
    cyc(0, 2'b00, 2'b00, 0, 0, 0);
    check("rec_count", int'(free_count), 32);
    check("rec_free0", int'(free_preg[0]), 35);
    check("rec_free1", int'(free_preg[1]), 36);
    cyc(0, 2'b10, 2'b00, 0, 0, 0);
    check("bit1_alone_gnt", int'(alloc_gnt), 0);
    cyc(0, 2'b11, 2'b00, 0, 0, 0);
    check("post_rec_gnt", int'(alloc_gnt), 3);
    cyc(0, 2'b00, 2'b00, 0, 0, 0);
    check("post_rec_count", int'(free_count), 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
